// File: rtl/sump_cmd_parser_pkg.sv
// Shared types and constants for the SUMP command parser: FSM encoding,
// framing constants and the opcodes the host commonly sends.
package sump_cmd_parser_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ARGS = 1'b1
    } state_t;

    localparam int LONG_CMD_BIT = 7;
    localparam int ARG_BYTES    = 4;

    localparam logic [7:0] OP_RESET       = 8'h00;
    localparam logic [7:0] OP_RUN         = 8'h01;
    localparam logic [7:0] OP_ID          = 8'h02;
    localparam logic [7:0] OP_SET_FLAGS   = 8'h82;
    localparam logic [7:0] OP_SET_DIVIDER = 8'h80;
    localparam logic [7:0] OP_SET_SIZE    = 8'h81;

endpackage

// File: rtl/sump_cmd_parser_if.sv
// Byte-in / command-out bundle between the receiver, the parser and the core.
// No backpressure anywhere: every rx_valid strobe is consumed.
interface sump_cmd_parser_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  opcode;
    logic [31:0] config_data;
    logic        execute;
    logic        cmd_active;
    logic        cmd_error;

    modport master (
        output rx_valid, rx_data,
        input  opcode, config_data, execute, cmd_active, cmd_error
    );

    modport slave (
        input  rx_valid, rx_data,
        output opcode, config_data, execute, cmd_active, cmd_error
    );

endinterface

// File: rtl/sump_cmd_timer.sv
// Inter-byte timeout counter; o_expire is combinational in the cycle the count sits at TIMEOUT_CYCLES-1.
// Clear dominates enable; TIMEOUT_CYCLES == 0 never expires.
module sump_cmd_timer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
    parameter int          TIMER_WIDTH    = 20
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [TIMER_WIDTH-1:0] LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 32'd1);

    logic [TIMER_WIDTH-1:0] r_count;

    // A byte arriving on the final cycle clears the timer, so it beats expiry.
    assign o_expire = (TIMEOUT_CYCLES != 32'd0) && i_enable && !i_clear && (r_count == LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expire) begin
            r_count <= r_count + TIMER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/sump_cmd_parser.sv
// SUMP byte-stream to command parser; execute follows the completing byte by 1 cycle.
// No backpressure: one byte per cycle accepted; stalled long commands are dropped on timeout.
module sump_cmd_parser
    import sump_cmd_parser_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
    parameter int          TIMER_WIDTH    = 20
) (
    input  logic                clock,
    input  logic                resetn,
    sump_cmd_parser_if.slave    bus
);

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [7:0]  r_pend_op;
    logic [31:0] r_pend_arg;
    logic [7:0]  r_opcode;
    logic [31:0] r_config_data;
    logic        r_execute;
    logic        r_cmd_active;
    logic        r_cmd_error;

    logic        w_timer_clear;
    logic        w_timer_en;
    logic        w_expire;

    assign w_timer_clear = bus.rx_valid || (r_state == ST_IDLE);
    assign w_timer_en    = (r_state == ST_ARGS);

    sump_cmd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_WIDTH    (TIMER_WIDTH)
    ) u_timer (
        .clock    (clock),
        .resetn   (resetn),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_idx         <= 2'd0;
            r_pend_op     <= 8'h00;
            r_pend_arg    <= 32'h0;
            r_opcode      <= 8'h00;
            r_config_data <= 32'h0;
            r_execute     <= 1'b0;
            r_cmd_active  <= 1'b0;
            r_cmd_error   <= 1'b0;
        end else begin
            r_execute   <= 1'b0;
            r_cmd_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data[LONG_CMD_BIT]) begin
                            r_pend_op    <= bus.rx_data;
                            r_idx        <= 2'd0;
                            r_state      <= ST_ARGS;
                            r_cmd_active <= 1'b1;
                        end else begin
                            r_opcode  <= bus.rx_data;
                            r_execute <= 1'b1;
                        end
                    end
                end
                ST_ARGS: begin
                    if (bus.rx_valid) begin
                        r_pend_arg[{r_idx, 3'b000} +: 8] <= bus.rx_data;
                        r_idx <= r_idx + 2'd1;
                        // Last byte goes straight to the output; the pending copy is not yet updated.
                        if (r_idx == 2'(ARG_BYTES - 1)) begin
                            r_opcode      <= r_pend_op;
                            r_config_data <= {bus.rx_data, r_pend_arg[23:0]};
                            r_execute     <= 1'b1;
                            r_state       <= ST_IDLE;
                            r_cmd_active  <= 1'b0;
                        end
                    end else if (w_expire) begin
                        r_state      <= ST_IDLE;
                        r_cmd_active <= 1'b0;
                        r_cmd_error  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cmd_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.opcode      = r_opcode;
    assign bus.config_data = r_config_data;
    assign bus.execute     = r_execute;
    assign bus.cmd_active  = r_cmd_active;
    assign bus.cmd_error   = r_cmd_error;

endmodule

// File: tb/tb_sump_cmd_parser.sv
// Directed bench for sump_cmd_parser with a 16-cycle timeout.
module tb_sump_cmd_parser;

    logic clock;
    logic resetn;

    sump_cmd_parser_if bus ();

    sump_cmd_parser #(
        .TIMEOUT_CYCLES (32'd16),
        .TIMER_WIDTH    (20)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    int exec_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always @(posedge clock) begin
        if (bus.execute)                  exec_cnt++;
        if (bus.cmd_error)                err_cnt++;
        if (bus.execute && bus.cmd_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // After this returns, outputs reflect the edge that sampled the byte.
    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    initial begin
        int snap_exec;
        int snap_err;
        int k;
        logic [7:0] bytes6 [10];

        resetn       = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(3);
        check("rst_opcode",     {24'h0, bus.opcode}, 32'h0);
        check("rst_config",     bus.config_data,     32'h0);
        check("rst_execute",    {31'h0, bus.execute},    32'h0);
        check("rst_cmd_active", {31'h0, bus.cmd_active}, 32'h0);
        check("rst_cmd_error",  {31'h0, bus.cmd_error},  32'h0);
        resetn = 1'b1;
        idle(2);

        // 1. short command
        send(8'h01);
        check("t1_execute", {31'h0, bus.execute}, 32'h1);
        check("t1_opcode",  {24'h0, bus.opcode},  32'h01);
        check("t1_config",  bus.config_data,      32'h0);
        tick();
        check("t1_execute_off", {31'h0, bus.execute}, 32'h0);

        // 2. long command, back to back
        send(8'h80);
        check("t2_active_b0", {31'h0, bus.cmd_active}, 32'h1);
        check("t2_opcode_held", {24'h0, bus.opcode}, 32'h01);
        send(8'h10);
        check("t2_active_b1", {31'h0, bus.cmd_active}, 32'h1);
        send(8'h32);
        check("t2_active_b2", {31'h0, bus.cmd_active}, 32'h1);
        send(8'h54);
        check("t2_active_b3", {31'h0, bus.cmd_active}, 32'h1);
        check("t2_no_early_exec", {31'h0, bus.execute}, 32'h0);
        send(8'h76);
        check("t2_execute", {31'h0, bus.execute},    32'h1);
        check("t2_opcode",  {24'h0, bus.opcode},     32'h80);
        check("t2_config",  bus.config_data,         32'h76543210);
        check("t2_active_off", {31'h0, bus.cmd_active}, 32'h0);
        tick();
        check("t2_execute_off", {31'h0, bus.execute}, 32'h0);

        // 3. timeout drops a partial command
        send(8'h82);
        send(8'hAA);
        snap_exec = exec_cnt;
        k = 0;
        while (!bus.cmd_error && k < 40) begin
            tick();
            k++;
        end
        check("t3_error_delay", k, 16);
        check("t3_error",       {31'h0, bus.cmd_error},  32'h1);
        check("t3_active_off",  {31'h0, bus.cmd_active}, 32'h0);
        check("t3_opcode_kept", {24'h0, bus.opcode},     32'h80);
        check("t3_config_kept", bus.config_data,         32'h76543210);
        tick();
        check("t3_error_off",   {31'h0, bus.cmd_error}, 32'h0);
        check("t3_no_exec",     exec_cnt - snap_exec,   0);
        send(8'h01);
        check("t3_recover_exec",   {31'h0, bus.execute}, 32'h1);
        check("t3_recover_opcode", {24'h0, bus.opcode},  32'h01);
        check("t3_recover_config", bus.config_data,      32'h76543210);
        tick();

        // 4. byte lands exactly on the expiry cycle
        snap_err = err_cnt;
        send(8'h81);
        send(8'h11);
        idle(15);
        send(8'h22);
        check("t4_active_b2", {31'h0, bus.cmd_active}, 32'h1);
        idle(15);
        send(8'h33);
        idle(15);
        send(8'h44);
        check("t4_execute", {31'h0, bus.execute}, 32'h1);
        check("t4_opcode",  {24'h0, bus.opcode},  32'h81);
        check("t4_config",  bus.config_data,      32'h44332211);
        tick();
        check("t4_no_error", err_cnt - snap_err, 0);

        // 5. reset mid-command
        send(8'h80);
        send(8'h11);
        send(8'h22);
        resetn = 1'b0;
        #1;
        check("t5_async_active", {31'h0, bus.cmd_active}, 32'h0);
        check("t5_async_opcode", {24'h0, bus.opcode},     32'h0);
        tick();
        resetn = 1'b1;
        snap_exec = exec_cnt;
        send(8'h02);
        check("t5_execute", {31'h0, bus.execute},    32'h1);
        check("t5_opcode",  {24'h0, bus.opcode},     32'h02);
        check("t5_config",  bus.config_data,         32'h0);
        check("t5_active",  {31'h0, bus.cmd_active}, 32'h0);
        tick();
        check("t5_one_exec", exec_cnt - snap_exec, 1);

        // 6. host reset sequence followed by a long command
        bytes6 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h82, 8'h01, 8'h00, 8'h00, 8'h00};
        snap_exec = exec_cnt;
        for (int i = 0; i < 5; i++) begin
            send(bytes6[i]);
            check($sformatf("t6_rst_exec%0d", i), {31'h0, bus.execute}, 32'h1);
            check($sformatf("t6_rst_op%0d", i),   {24'h0, bus.opcode},  32'h00);
        end
        for (int i = 5; i < 10; i++) send(bytes6[i]);
        check("t6_execute", {31'h0, bus.execute}, 32'h1);
        check("t6_opcode",  {24'h0, bus.opcode},  32'h82);
        check("t6_config",  bus.config_data,      32'h00000001);
        tick();
        check("t6_exec_count", exec_cnt - snap_exec, 6);
        check("never_both",    both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
